// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared constants and types for the raster timing generator.
//   - 720x480p60 default geometry (active/front/sync/back per axis, totals)
//   - phase_e: the four raster phases, used by both the horizontal and vertical FSMs
//   - POS_W: width of the position counters and position outputs
//   - axis_total(): sum of the four phase lengths of one axis
package video_timing_pkg;

    localparam int unsigned POS_W = 10;

    typedef enum logic [1:0] {
        PhAct   = 2'd0,
        PhFront = 2'd1,
        PhSync  = 2'd2,
        PhBack  = 2'd3
    } phase_e;

    function automatic int unsigned axis_total(input int unsigned act, input int unsigned front,
                                               input int unsigned sync, input int unsigned back);
        return act + front + sync + back;
    endfunction

    localparam int unsigned DEF_H_ACTIVE = 720;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 62;
    localparam int unsigned DEF_H_BACK   = 60;
    localparam int unsigned DEF_H_TOTAL  =
        axis_total(DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);

    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 9;
    localparam int unsigned DEF_V_SYNC   = 6;
    localparam int unsigned DEF_V_BACK   = 30;
    localparam int unsigned DEF_V_TOTAL  =
        axis_total(DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/video_axis_counter.sv
// video_axis_counter
// One raster axis: a position counter plus the phase FSM (Act -> Front -> Sync -> Back).
// Ports:
//   i_clk    clock
//   i_reset  synchronous active-high reset (count 0, phase Act)
//   i_step   advance by one position this cycle
//   o_cnt    current position, 0..TOTAL-1
//   o_phase  current phase (phase_e encoding)
//   o_wrap   high in the cycle the count steps from TOTAL-1 back to 0
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FRONT  = DEF_H_FRONT,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BACK   = DEF_H_BACK
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_step,
    output logic [POS_W-1:0] o_cnt,
    output logic [1:0]       o_phase,
    output logic             o_wrap
);

    localparam int unsigned TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

    // Elaboration-time geometry checks.
    if (ACTIVE == 0 || FRONT == 0 || SYNC == 0 || BACK == 0) begin : g_bad_len
        $error("video_axis_counter: zero-length phase is illegal");
    end
    if (TOTAL > (1 << POS_W)) begin : g_bad_total
        $error("video_axis_counter: axis total exceeds counter range");
    end

    // Last position of each phase; the FSM leaves the phase after this position.
    localparam logic [POS_W-1:0] LAST_ACT   = POS_W'(ACTIVE - 1);
    localparam logic [POS_W-1:0] LAST_FRONT = POS_W'(ACTIVE + FRONT - 1);
    localparam logic [POS_W-1:0] LAST_SYNC  = POS_W'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [POS_W-1:0] LAST_BACK  = POS_W'(TOTAL - 1);

    logic [POS_W-1:0] r_cnt;
    logic [POS_W-1:0] w_cntNext;
    phase_e           r_phase;
    phase_e           w_phaseNext;
    logic             w_wrap;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_phase <= PhAct;
        end else begin
            r_cnt   <= w_cntNext;
            r_phase <= w_phaseNext;
        end
    end

    always_comb begin
        w_cntNext   = r_cnt;
        w_phaseNext = r_phase;
        w_wrap      = 1'b0;
        if (i_step) begin
            if (r_cnt == LAST_BACK) begin
                w_cntNext = '0;
                w_wrap    = 1'b1;
            end else begin
                w_cntNext = r_cnt + POS_W'(1);
            end
            case (r_phase)
                PhAct:   if (r_cnt == LAST_ACT)   w_phaseNext = PhFront;
                PhFront: if (r_cnt == LAST_FRONT) w_phaseNext = PhSync;
                PhSync:  if (r_cnt == LAST_SYNC)  w_phaseNext = PhBack;
                PhBack:  if (r_cnt == LAST_BACK)  w_phaseNext = PhAct;
                default: w_phaseNext = PhAct;
            endcase
        end
    end

    assign o_cnt   = r_cnt;
    assign o_phase = r_phase;
    assign o_wrap  = w_wrap;

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
// Free-running raster timing generator (default 720x480p60 at 27 MHz).
// All outputs are registered from the same internal (hCnt, vCnt, phase) state, so they
// describe one raster position and lag the internal counters by one cycle.
// Ports:
//   pixelClock       pixel clock
//   reset            synchronous active-high reset
//   hPosCounter      horizontal position 0..H_TOTAL-1
//   vPosCounter      vertical position 0..V_TOTAL-1
//   inActiveDisplay  high inside the visible window
//   hSync / vSync    SYNC_POL during the sync phase, ~SYNC_POL otherwise
//   lineStart        one-cycle pulse at h = 0
//   frameStart       one-cycle pulse at h = 0, v = 0
//   frameCount       frame counter (only with VIDEO_TIMING_FRAME_COUNT_EN defined)
// Build option: define VIDEO_TIMING_FRAME_COUNT_EN to add frameCount.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic             pixelClock,
    input  logic             reset,
    output logic [POS_W-1:0] hPosCounter,
    output logic [POS_W-1:0] vPosCounter,
    output logic             inActiveDisplay,
    output logic             hSync,
    output logic             vSync,
    output logic             lineStart,
    output logic             frameStart
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    ,
    output logic [15:0]      frameCount
`endif
);

    logic [POS_W-1:0] w_hCnt;
    logic [POS_W-1:0] w_vCnt;
    logic [1:0]       w_hPhase;
    logic [1:0]       w_vPhase;
    logic             w_hWrap;
    logic             w_vWrap;

    video_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .i_clk   (pixelClock),
        .i_reset (reset),
        .i_step  (1'b1),
        .o_cnt   (w_hCnt),
        .o_phase (w_hPhase),
        .o_wrap  (w_hWrap)
    );

    video_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .i_clk   (pixelClock),
        .i_reset (reset),
        .i_step  (w_hWrap),
        .o_cnt   (w_vCnt),
        .o_phase (w_vPhase),
        .o_wrap  (w_vWrap)
    );

    // r_lineHead / r_frameHead are high while the internal counters sit at h = 0 / (0,0).
    // They are set by reset and by the wrap that lands the counters there, which avoids a
    // wide position compare on the pulse path.
    logic             r_lineHead;
    logic             r_frameHead;
    logic [POS_W-1:0] r_hPos;
    logic [POS_W-1:0] r_vPos;
    logic             r_active;
    logic             r_hSync;
    logic             r_vSync;
    logic             r_lineStart;
    logic             r_frameStart;

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            r_lineHead   <= 1'b1;
            r_frameHead  <= 1'b1;
            r_hPos       <= '0;
            r_vPos       <= '0;
            r_active     <= 1'b0;
            r_hSync      <= ~SYNC_POL;
            r_vSync      <= ~SYNC_POL;
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
        end else begin
            r_lineHead   <= w_hWrap;
            r_frameHead  <= w_vWrap;
            r_hPos       <= w_hCnt;
            r_vPos       <= w_vCnt;
            r_active     <= (w_hPhase == PhAct) && (w_vPhase == PhAct);
            r_hSync      <= (w_hPhase == PhSync) ? SYNC_POL : ~SYNC_POL;
            r_vSync      <= (w_vPhase == PhSync) ? SYNC_POL : ~SYNC_POL;
            r_lineStart  <= r_lineHead;
            r_frameStart <= r_frameHead;
        end
    end

    assign hPosCounter     = r_hPos;
    assign vPosCounter     = r_vPos;
    assign inActiveDisplay = r_active;
    assign hSync           = r_hSync;
    assign vSync           = r_vSync;
    assign lineStart       = r_lineStart;
    assign frameStart      = r_frameStart;

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    logic [15:0] r_frameCount;
    logic        r_frameSeen;

    // Updates on the same edge that raises frameStart; the first frame after reset shows 0.
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            r_frameCount <= '0;
            r_frameSeen  <= 1'b0;
        end else if (r_frameHead) begin
            if (r_frameSeen) begin
                r_frameCount <= r_frameCount + 16'd1;
            end
            r_frameSeen <= 1'b1;
        end
    end

    assign frameCount = r_frameCount;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

    typedef struct packed {
        int unsigned ha;
        int unsigned hf;
        int unsigned hs;
        int unsigned hb;
        int unsigned va;
        int unsigned vf;
        int unsigned vs;
        int unsigned vb;
    } geo_t;

    typedef struct packed {
        logic [19:0] pos;    // {v, h}
        logic [4:0]  flags;  // {active, hSync, vSync, lineStart, frameStart}
        logic [15:0] fc;
    } exp_t;

    localparam geo_t BIG_GEO   = '{ha: 720, hf: 16, hs: 62, hb: 60,
                                   va: 480, vf: 9,  vs: 6,  vb: 30};
    localparam geo_t SMALL_GEO = '{ha: 16, hf: 1, hs: 2, hb: 1,
                                   va: 8,  vf: 1, vs: 2, vb: 1};

    localparam int TOTAL_CYC = 3400;
    localparam int RST_AT    = 2120;  // reset edge right after big shows (400,2)

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic [9:0]  big_h, big_v, small_h, small_v;
    logic        big_act, big_hs, big_vs, big_ls, big_fs;
    logic        small_act, small_hs, small_vs, small_ls, small_fs;
    logic [15:0] big_fc, small_fc;

    video_timing_gen u_big (
        .pixelClock      (clk),
        .reset           (reset),
        .hPosCounter     (big_h),
        .vPosCounter     (big_v),
        .inActiveDisplay (big_act),
        .hSync           (big_hs),
        .vSync           (big_vs),
        .lineStart       (big_ls),
        .frameStart      (big_fs)
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        ,
        .frameCount      (big_fc)
`endif
    );

    video_timing_gen #(
        .H_ACTIVE (16),
        .H_FRONT  (1),
        .H_SYNC   (2),
        .H_BACK   (1),
        .V_ACTIVE (8),
        .V_FRONT  (1),
        .V_SYNC   (2),
        .V_BACK   (1),
        .SYNC_POL (1'b0)
    ) u_small (
        .pixelClock      (clk),
        .reset           (reset),
        .hPosCounter     (small_h),
        .vPosCounter     (small_v),
        .inActiveDisplay (small_act),
        .hSync           (small_hs),
        .vSync           (small_vs),
        .lineStart       (small_ls),
        .frameStart      (small_fs)
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        ,
        .frameCount      (small_fc)
`endif
    );

`ifndef VIDEO_TIMING_FRAME_COUNT_EN
    assign big_fc   = '0;
    assign small_fc = '0;
`endif

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    exp_t q_big[$];
    exp_t q_small[$];

    // Reference model: expected port values for one clock edge, from the window formulas.
    task automatic model_step(input bit rst, input geo_t g, inout int unsigned h,
                              inout int unsigned v, inout logic [15:0] fc, inout bit seen,
                              output exp_t e);
        int unsigned ht, vt;
        bit act, hs_win, vs_win;
        ht = g.ha + g.hf + g.hs + g.hb;
        vt = g.va + g.vf + g.vs + g.vb;
        if (rst) begin
            e.pos   = '0;
            e.flags = 5'b01100;
            fc      = '0;
            seen    = 1'b0;
            e.fc    = '0;
            h       = 0;
            v       = 0;
        end else begin
            act    = (h < g.ha) && (v < g.va);
            hs_win = (h >= g.ha + g.hf) && (h < g.ha + g.hf + g.hs);
            vs_win = (v >= g.va + g.vf) && (v < g.va + g.vf + g.vs);
            e.pos   = {10'(v), 10'(h)};
            // active-low sync: 0 inside the window
            e.flags = {act, !hs_win, !vs_win, h == 0, (h == 0) && (v == 0)};
            if (h == 0 && v == 0) begin
                if (seen) fc = fc + 16'd1;
                seen = 1'b1;
            end
            e.fc = fc;
            h++;
            if (h == ht) begin
                h = 0;
                v++;
                if (v == vt) v = 0;
            end
        end
    endtask

    int unsigned bh = 0, bv = 0, sh = 0, sv = 0;
    logic [15:0] bfc = '0, sfc = '0;
    bit bseen = 1'b0, sseen = 1'b0;
    int last_fs = -1;

    initial begin
        exp_t e;
        reset = 1'b1;
        for (int c = 0; c < TOTAL_CYC; c++) begin
            reset = (c < 3) || (c == RST_AT);
            @(posedge clk);
            model_step(reset, BIG_GEO, bh, bv, bfc, bseen, e);
            q_big.push_back(e);
            model_step(reset, SMALL_GEO, sh, sv, sfc, sseen, e);
            q_small.push_back(e);
            @(negedge clk);

            if (q_big.size() == 0 || q_small.size() == 0) begin
                check_eq("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = q_big.pop_front();
                check_eq("big_pos", {12'd0, big_v, big_h}, {12'd0, e.pos});
                check_eq("big_flags", {27'd0, big_act, big_hs, big_vs, big_ls, big_fs},
                         {27'd0, e.flags});
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
                check_eq("big_frameCount", {16'd0, big_fc}, {16'd0, e.fc});
`endif
                e = q_small.pop_front();
                check_eq("small_pos", {12'd0, small_v, small_h}, {12'd0, e.pos});
                check_eq("small_flags",
                         {27'd0, small_act, small_hs, small_vs, small_ls, small_fs},
                         {27'd0, e.flags});
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
                check_eq("small_frameCount", {16'd0, small_fc}, {16'd0, e.fc});
`endif
            end

            // 20x12 raster: frameStart every 240 cycles between resets.
            if (reset) begin
                last_fs = -1;
            end else if (small_fs === 1'b1) begin
                if (last_fs >= 0) check_eq("small_frame_period", 32'(c - last_fs), 32'd240);
                last_fs = c;
            end

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
            // Preload the counter so the next frame start must wrap it to 0.
            if (c == 1000) begin
                u_small.r_frameCount = 16'hFFFF;
                sfc = 16'hFFFF;
            end
`endif
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Free-running raster timing generator for the HDMI transmit path. It produces the registered horizontal/vertical position, the active-display flag and the sync pulses from the pixel clock. These outputs drive the pixel source (colour-bar/pattern logic) and the TMDS encoder's control-period selection. All timing outputs are mutually aligned, so a pixel source that decodes position combinationally stays coherent with sync.

## Interface
Parameters (defaults: 720x480p60, 27 MHz pixel clock):
- H_ACTIVE, 720, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 62, hsync width (pixels)
- H_BACK, 60, horizontal back porch; H_TOTAL = 858
- V_ACTIVE, 480, visible lines
- V_FRONT, 9, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BACK, 30, vertical back porch; V_TOTAL = 525
- SYNC_POL, 1'b0, asserted sync level (0 = active-low)

Ports:
- pixelClock  in  1  pixel clock; the only clock in the block
- reset  in  1  synchronous, active-high
- hPosCounter  out  10  horizontal position, 0..H_TOTAL-1
- vPosCounter  out  10  vertical position, 0..V_TOTAL-1
- inActiveDisplay  out  1  high when h < H_ACTIVE and v < V_ACTIVE
- hSync  out  1  SYNC_POL when H_ACTIVE+H_FRONT ≤ h < H_ACTIVE+H_FRONT+H_SYNC
- vSync  out  1  SYNC_POL when V_ACTIVE+V_FRONT ≤ v < V_ACTIVE+V_FRONT+V_SYNC; vSync changes only at h = 0
- lineStart  out  1  one-cycle pulse at h = 0
- frameStart  out  1  one-cycle pulse at h = 0, v = 0

## Operation
- Internal counters hCnt and vCnt, each 10 bits.
  - hCnt increments every cycle and wraps from H_TOTAL-1 to 0.
  - vCnt increments when hCnt wraps, and wraps from V_TOTAL-1 to 0.
- Horizontal phase FSM: H_ACT → H_FP → H_SYNC → H_BP → H_ACT.
  - Each transition occurs when hCnt reaches the last pixel of the current phase.
  - The state is registered alongside hCnt; no decoding of the wide compare is needed for hSync.
- Vertical phase FSM: V_ACT → V_FP → V_SYNC → V_BP → V_ACT.
  - It advances only on the hCnt wrap, at the same phase boundaries in lines.
- Every output is registered from the current (hCnt, vCnt, phase) values in the same edge, so all outputs describe the same raster position.
- Zero-length porch parameters are illegal; an elaboration-time check must fail the build.
- Sum checks: H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024, both enforced at elaboration.

## Timing
- Reset (sampled high at a rising edge):
  - hCnt, vCnt ← 0; FSMs ← H_ACT/V_ACT.
  - Outputs: positions 0, inActiveDisplay 0, hSync/vSync ← ~SYNC_POL, lineStart 0, frameStart 0.
- First edge with reset low: outputs present position (0,0), inActiveDisplay 1, lineStart 1, frameStart 1. Internal hCnt becomes 1.
- Output latency: one cycle from the internal counter to the ports. Positions on the ports increase by one per cycle with no gaps or repeats.
- Line wrap: port h = 857 is followed by h = 0, and v increments in that same cycle.
- Frame wrap: port (857, 524) is followed by (0, 0) with frameStart = 1.
- Reset asserted mid-frame takes effect at the next edge and overrides every other update. Raster restarts exactly as after power-up.

## Configuration
- VIDEO_TIMING_FRAME_COUNT_EN defined:
  - Adds output frameCount [15:0].
  - It resets to 0, increments in the cycle frameStart is driven high (except the first frameStart after reset, which shows 0), and wraps 65535 → 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

## Structure
- Package video_timing_pkg holds:
  - The 480p60 default constants (H_*/V_* values, totals).
  - The phase enum typedef, shared by both FSMs.
  - The position width constant (10).
- Sub-module video_axis_counter:
  - Parameterised counter plus phase FSM with step-enable and wrap output.
  - Instantiated twice: horizontal with step tied high, vertical with step driven by the horizontal wrap.

## Test plan
- Release reset, then check the first output cycle: h=0, v=0, inActiveDisplay=1, lineStart=1, frameStart=1, hSync=1, vSync=1.
- Run one line: inActiveDisplay falls at h=720. hSync is 0 exactly for h=736..797 (62 cycles). h=857 is followed by h=0 with v=1.
- Run one frame: vSync is 0 for v=489..494, transitioning only at h=0. frameStart pulses every 450450 cycles. The frame-wrap step from (857,524) to (0,0) is exact.
- Assert reset for 1 cycle at (400,300): the next cycle shows reset values, then (0,0) with frameStart=1.
- Override parameters to a 16x8 raster with porches 1/2/1 (horizontal and vertical). Check totals of 20x12, and sync and active windows cycle-exact over 3 frames.
- With VIDEO_TIMING_FRAME_COUNT_EN: frameCount reads 0,1,2 at successive frameStart pulses. Force a wrap from 65535 to 0.
